board_sprite_sequencer: RTL and testbench

- Sequences the shared piece-sprite ROM and the board-state RAM so that every 55x55 board square shows the correct piece.
- Tracks the VGA beam (DrawX/DrawY) with incremental counters instead of dividers or multipliers.
- Each pixel goes through a 4-stage pipeline: board RAM read, ROM address generation, then palette index plus square attributes.
- Sits between the VGA controller and the colour mapper; the colour mapper owns the palette and the final RGB.

---
 rtl/chess_pkg.sv | 45 ++++
 rtl/beam_square_tracker.sv | 129 ++++++++++++
 rtl/board_sprite_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_board_sprite_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// chess_pkg
//   Shared definitions for the board sprite path: piece codes held in the
//   board RAM, the colour bit position, sprite geometry, and the base
//   address of each sprite inside the stacked sprite ROM.
//   No ports; imported by beam_square_tracker and board_sprite_sequencer.
package chess_pkg;

    // Low three bits of a board RAM word; codes 0 and 7 both mean empty.
    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } piece_e;

    // Vertical tracker states.
    typedef enum logic {
        Y_OFF = 1'b0,
        Y_ON  = 1'b1
    } y_state_e;

    localparam int COLOUR_BIT   = 3;
    localparam int SQ_PIX       = 55;
    localparam int SPRITE_WORDS = SQ_PIX * SQ_PIX;

    // Start of a sprite in the ROM. 'words' is always an elaboration
    // constant, so every case arm folds to a fixed value and the result is
    // a small constant table selected by the piece type.
    function automatic int unsigned sprite_base(input logic [2:0] kind,
                                                input int unsigned words);
        case (kind)
            PAWN:    return 0;
            KNIGHT:  return words;
            BISHOP:  return 2 * words;
            ROOK:    return 3 * words;
            QUEEN:   return 4 * words;
            KING:    return 5 * words;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/beam_square_tracker.sv
// beam_square_tracker
//   Follows the VGA beam with incremental counters and reports which board
//   square (row, col) the current pixel falls in, the pixel's column offset
//   inside that square, and the row offset pre-scaled by SQ (y_base).
//   Ports:
//     vga_clk, reset      pixel clock, async active-high reset
//     DrawX, DrawY        beam position for the current cycle
//     on_board            current pixel lies inside the 8x8 board
//     row, col            square coordinates of the current pixel
//     x_off               column offset inside the square (0..SQ-1)
//     y_base              row offset inside the square times SQ
module beam_square_tracker
    import chess_pkg::*;
#(
    parameter int BOARD_X0 = 100,
    parameter int BOARD_Y0 = 20,
    parameter int SQ       = SQ_PIX,
    parameter int ROM_AW   = 15
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic              on_board,
    output logic [2:0]        row,
    output logic [2:0]        col,
    output logic [5:0]        x_off,
    output logic [ROM_AW-1:0] y_base
);

    localparam logic [5:0] LAST_OFF = 6'(SQ - 1);

    logic [2:0]        col_q, col_d;
    logic [5:0]        x_off_q, x_off_d;
    logic              in_x_q, in_x_d;

    y_state_e          y_state, y_next;
    logic [2:0]        row_q, row_d;
    logic [5:0]        y_off_q, y_off_d;
    logic [ROM_AW-1:0] y_base_q, y_base_d;

    // The registers hold the previous pixel's position; the comb values are
    // the current pixel's, so the square is known in the same cycle DrawX is.
    always_comb begin
        col_d   = col_q;
        x_off_d = x_off_q;
        in_x_d  = 1'b0;
        if (DrawX == 10'(BOARD_X0)) begin
            col_d   = 3'd0;
            x_off_d = 6'd0;
            in_x_d  = 1'b1;
        end else if (in_x_q) begin
            in_x_d = 1'b1;
            if (x_off_q == LAST_OFF) begin
                x_off_d = 6'd0;
                col_d   = col_q + 3'd1;
                if (col_q == 3'd7) begin
                    in_x_d = 1'b0;
                end
            end else begin
                x_off_d = x_off_q + 6'd1;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            col_q   <= 3'd0;
            x_off_q <= 6'd0;
            in_x_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            x_off_q <= x_off_d;
            in_x_q  <= in_x_d;
        end
    end

    // Line tracker: advances once per line at DrawX==0, long before the
    // board's first column, so its registered values serve the whole line.
    // The first board row resyncs unconditionally, which also keeps a
    // partially seen frame after reset from being drawn.
    always_comb begin
        y_next   = y_state;
        row_d    = row_q;
        y_off_d  = y_off_q;
        y_base_d = y_base_q;
        if (DrawX == 10'd0) begin
            if (DrawY == 10'(BOARD_Y0)) begin
                y_next   = Y_ON;
                row_d    = 3'd0;
                y_off_d  = 6'd0;
                y_base_d = '0;
            end else if (y_state == Y_ON) begin
                if (y_off_q == LAST_OFF) begin
                    y_off_d  = 6'd0;
                    y_base_d = '0;
                    row_d    = row_q + 3'd1;
                    if (row_q == 3'd7) begin
                        y_next = Y_OFF;
                    end
                end else begin
                    y_off_d  = y_off_q + 6'd1;
                    y_base_d = y_base_q + ROM_AW'(SQ);
                end
            end
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            y_state  <= Y_OFF;
            row_q    <= 3'd0;
            y_off_q  <= 6'd0;
            y_base_q <= '0;
        end else begin
            y_state  <= y_next;
            row_q    <= row_d;
            y_off_q  <= y_off_d;
            y_base_q <= y_base_d;
        end
    end

    assign on_board = in_x_d && (y_state == Y_ON);
    assign row      = row_q;
    assign col      = col_d;
    assign x_off    = x_off_d;
    assign y_base   = y_base_q;

endmodule

// File: rtl/board_sprite_sequencer.sv
// board_sprite_sequencer
//   Drives the board-state RAM and the shared sprite ROM so every board
//   square shows its piece, and hands the colour mapper a palette index
//   plus square attributes, 4 cycles after the pixel's DrawX/DrawY.
//   Ports:
//     vga_clk, reset                 pixel clock, async active-high reset
//     DrawX, DrawY, blank            beam position and active-video flag
//     sel_sq, sel_valid              selected square, latched per frame
//     board_rd_addr / board_rd_data  board RAM read port (1-cycle latency)
//     rom_addr / rom_q               sprite ROM (read on the negedge)
//     pix_*                          pixel outputs for the colour mapper
module board_sprite_sequencer
    import chess_pkg::*;
#(
    parameter int BOARD_X0 = 100,
    parameter int BOARD_Y0 = 20,
    parameter int SQ       = SQ_PIX,
    parameter int ROM_AW   = 15
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [5:0]        sel_sq,
    input  logic              sel_valid,
    output logic [5:0]        board_rd_addr,
    input  logic [3:0]        board_rd_data,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [1:0]        rom_q,
    output logic [1:0]        pix_idx,
    output logic              pix_is_piece,
    output logic              pix_black,
    output logic              pix_dark,
    output logic              pix_on_board,
    output logic              pix_highlight,
    output logic              pix_blank
);

    localparam int unsigned SQ_WORDS = SQ * SQ;

    logic              trk_on_board;
    logic [2:0]        trk_row, trk_col;
    logic [5:0]        trk_x_off;
    logic [ROM_AW-1:0] trk_y_base;

    logic [5:0]        sel_q;
    logic              sel_v_q;

    logic              s1_on, s1_dark, s1_hl, s1_blank;
    logic [5:0]        s1_x_off;
    logic [ROM_AW-1:0] s1_y_base;

    logic              s2_on, s2_dark, s2_hl, s2_blank;
    logic [5:0]        s2_x_off;
    logic [ROM_AW-1:0] s2_y_base;

    logic              s3_valid, s3_black, s3_on, s3_dark, s3_hl, s3_blank;

    logic [2:0]        kind;
    logic              piece_ok;
    logic [ROM_AW-1:0] rom_next;

    beam_square_tracker #(
        .BOARD_X0 (BOARD_X0),
        .BOARD_Y0 (BOARD_Y0),
        .SQ       (SQ),
        .ROM_AW   (ROM_AW)
    ) u_tracker (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .on_board (trk_on_board),
        .row      (trk_row),
        .col      (trk_col),
        .x_off    (trk_x_off),
        .y_base   (trk_y_base)
    );

    // Selection only changes at the top-left of the frame, so a selection
    // made mid-frame never splits one highlight across two squares.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            sel_q   <= 6'd0;
            sel_v_q <= 1'b0;
        end else if (DrawX == 10'd0 && DrawY == 10'd0) begin
            sel_q   <= sel_sq;
            sel_v_q <= sel_valid;
        end
    end

    // Stages 1 and 2: issue the board RAM read, then carry the square
    // attributes alongside while the RAM answers.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            board_rd_addr <= 6'd0;
            s1_on         <= 1'b0;
            s1_dark       <= 1'b0;
            s1_hl         <= 1'b0;
            s1_blank      <= 1'b0;
            s1_x_off      <= 6'd0;
            s1_y_base     <= '0;
            s2_on         <= 1'b0;
            s2_dark       <= 1'b0;
            s2_hl         <= 1'b0;
            s2_blank      <= 1'b0;
            s2_x_off      <= 6'd0;
            s2_y_base     <= '0;
        end else begin
            board_rd_addr <= {trk_row, trk_col};
            s1_on         <= trk_on_board;
            s1_dark       <= trk_row[0] ^ trk_col[0];
            s1_hl         <= sel_v_q && ({trk_row, trk_col} == sel_q);
            s1_blank      <= blank;
            s1_x_off      <= trk_x_off;
            s1_y_base     <= trk_y_base;
            s2_on         <= s1_on;
            s2_dark       <= s1_dark;
            s2_hl         <= s1_hl;
            s2_blank      <= s1_blank;
            s2_x_off      <= s1_x_off;
            s2_y_base     <= s1_y_base;
        end
    end

    // Stage 3 address: sprite base from the constant table plus the offsets
    // already tracked by the counters. Empty or off-board pixels park the
    // ROM at address 0 and mark the pixel as carrying no piece.
    always_comb begin
        kind     = board_rd_data[2:0];
        piece_ok = s2_on && (kind != EMPTY) && (kind != 3'd7);
        rom_next = '0;
        if (piece_ok) begin
            rom_next = ROM_AW'(sprite_base(kind, SQ_WORDS)) + s2_y_base
                       + {{(ROM_AW-6){1'b0}}, s2_x_off};
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_addr <= '0;
            s3_valid <= 1'b0;
            s3_black <= 1'b0;
            s3_on    <= 1'b0;
            s3_dark  <= 1'b0;
            s3_hl    <= 1'b0;
            s3_blank <= 1'b0;
        end else begin
            rom_addr <= rom_next;
            s3_valid <= piece_ok;
            s3_black <= board_rd_data[COLOUR_BIT];
            s3_on    <= s2_on;
            s3_dark  <= s2_dark;
            s3_hl    <= s2_hl;
            s3_blank <= s2_blank;
        end
    end

    // Stage 4: rom_q is only trusted when stage 3 issued a real sprite
    // address, so ROM contents left over from before a reset never leak out.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            pix_idx       <= 2'd0;
            pix_is_piece  <= 1'b0;
            pix_black     <= 1'b0;
            pix_dark      <= 1'b0;
            pix_on_board  <= 1'b0;
            pix_highlight <= 1'b0;
            pix_blank     <= 1'b0;
        end else begin
            pix_idx       <= s3_valid ? rom_q : 2'd0;
            pix_is_piece  <= s3_valid && (rom_q != 2'd0);
            pix_black     <= s3_valid && s3_black;
            pix_dark      <= s3_on && s3_dark;
            pix_on_board  <= s3_on;
            pix_highlight <= s3_on && s3_hl;
            pix_blank     <= s3_blank;
        end
    end

endmodule

// File: tb/tb_board_sprite_sequencer.sv
// tb_board_sprite_sequencer
//   Scans a VGA beam over the sequencer, plays board RAM and sprite ROM with
//   random contents, and compares every output against a pixel-coordinate
//   model. Fixed vectors and hand sequences cover the square edges, board
//   edges, selection latch and mid-frame reset.
module tb_board_sprite_sequencer;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic [5:0]  sel_sq;
    logic        sel_valid;
    logic [5:0]  board_rd_addr;
    logic [3:0]  board_rd_data;
    logic [14:0] rom_addr;
    logic [1:0]  rom_q;
    logic [1:0]  pix_idx;
    logic        pix_is_piece, pix_black, pix_dark, pix_on_board;
    logic        pix_highlight, pix_blank;

    always #5 vga_clk = ~vga_clk;

    board_sprite_sequencer dut (
        .vga_clk       (vga_clk),
        .reset         (reset),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .blank         (blank),
        .sel_sq        (sel_sq),
        .sel_valid     (sel_valid),
        .board_rd_addr (board_rd_addr),
        .board_rd_data (board_rd_data),
        .rom_addr      (rom_addr),
        .rom_q         (rom_q),
        .pix_idx       (pix_idx),
        .pix_is_piece  (pix_is_piece),
        .pix_black     (pix_black),
        .pix_dark      (pix_dark),
        .pix_on_board  (pix_on_board),
        .pix_highlight (pix_highlight),
        .pix_blank     (pix_blank)
    );

    // One pixel in flight: its position as the model sees it plus the RAM
    // and ROM data the bench played back for it.
    typedef struct {
        bit valid;
        bit on;
        int row, col, xo, yo;
        bit blank, hl;
        bit ov;
        int ovCode, ovRq;
        int code, rq;
    } pix_t;

    typedef struct {
        int x, y, code, rq;
        int addr, rom;
        int idx, piece, black, dark, on, hl;
    } vec_t;

    pix_t hist[8];
    vec_t vecs[11];
    int   cyc = 8;
    int   checks = 0;
    int   errors = 0;
    bit   synced = 0;
    bit   selLv = 0;
    int   selL = 0;
    int   bx = 0;
    int   by = 0;

    function automatic bit pieceOk(pix_t p);
        int kind = p.code & 7;
        return p.valid && p.on && kind >= 1 && kind <= 6;
    endfunction

    function automatic int expRom(pix_t p);
        if (!pieceOk(p)) return 0;
        return ((p.code & 7) - 1) * 3025 + p.yo * 55 + p.xo;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one beam pixel, plays the RAM/ROM data owed to older pixels,
    // advances one clock and compares every output that just became due.
    task automatic applyStimulus(input int x, input int y, input bit ov,
                                 input int ovCode, input int ovRq);
        pix_t p;
        int k;
        bit ok;
        p = '{default: 0};
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = (x < 640 && y < 480);
        if (!reset) begin
            if (x == 0 && y == 20) synced = 1;
            p.valid = 1;
            p.on = synced && x >= 100 && x < 540 && y >= 20 && y < 460;
            if (p.on) begin
                p.col = (x - 100) / 55;
                p.xo  = (x - 100) % 55;
                p.row = (y - 20) / 55;
                p.yo  = (y - 20) % 55;
            end
            p.blank = blank;
            p.hl = p.on && selLv && (p.row * 8 + p.col) == selL;
            if (x == 0 && y == 0) begin
                selL  = sel_sq;
                selLv = sel_valid;
            end
        end
        p.ov = ov;
        p.ovCode = ovCode;
        p.ovRq = ovRq;
        hist[cyc & 7] = p;
        k = (cyc - 2) & 7;
        hist[k].code = hist[k].ov ? hist[k].ovCode : int'($urandom_range(0, 15));
        board_rd_data = 4'(hist[k].code);
        k = (cyc - 3) & 7;
        hist[k].rq = hist[k].ov ? hist[k].ovRq : int'($urandom_range(0, 3));
        rom_q = 2'(hist[k].rq);

        @(posedge vga_clk);
        #1;
        cyc++;

        p = hist[(cyc - 1) & 7];
        if (!p.valid) checkOutput("board_rd_addr(reset)", board_rd_addr, 0);
        else if (p.on) checkOutput("board_rd_addr", board_rd_addr, p.row * 8 + p.col);
        p = hist[(cyc - 3) & 7];
        checkOutput("rom_addr", rom_addr, expRom(p));
        p = hist[(cyc - 4) & 7];
        ok = pieceOk(p);
        checkOutput("pix_idx", pix_idx, ok ? p.rq : 0);
        checkOutput("pix_is_piece", pix_is_piece, (ok && p.rq != 0) ? 1 : 0);
        checkOutput("pix_black", pix_black, (ok && ((p.code >> 3) & 1) == 1) ? 1 : 0);
        checkOutput("pix_dark", pix_dark, (p.valid && p.on && ((p.row + p.col) % 2) == 1) ? 1 : 0);
        checkOutput("pix_on_board", pix_on_board, (p.valid && p.on) ? 1 : 0);
        checkOutput("pix_highlight", pix_highlight, (p.valid && p.hl) ? 1 : 0);
        checkOutput("pix_blank", pix_blank, (p.valid && p.blank) ? 1 : 0);
    endtask

    task automatic stepBeam(input bit ov, input int c, input int r);
        applyStimulus(bx, by, ov, c, r);
        bx++;
        if (bx == 800) begin
            bx = 0;
            by = (by + 1) % 525;
        end
    endtask

    // Moves the beam forward to (x,y). Lines not of interest are reduced to
    // their DrawX==0 pixel; a line already started is always finished.
    task automatic advanceTo(input int x, input int y);
        int n = 0;
        while (!(bx == x && by == y)) begin
            if (bx == 0 && by != y) begin
                applyStimulus(0, by, 0, 0, 0);
                by = (by + 1) % 525;
            end else begin
                stepBeam(0, 0, 0);
            end
            n++;
            if (n > 60000) begin
                $display("[TB] FAIL advanceTo timeout actual=%0d,%0d required=%0d,%0d", bx, by, x, y);
                errors++;
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "[TB] beam never reached target");
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".board_rd_addr"}, board_rd_addr, 0);
        checkOutput({tag, ".rom_addr"}, rom_addr, 0);
        checkOutput({tag, ".pix_idx"}, pix_idx, 0);
        checkOutput({tag, ".pix_is_piece"}, pix_is_piece, 0);
        checkOutput({tag, ".pix_black"}, pix_black, 0);
        checkOutput({tag, ".pix_dark"}, pix_dark, 0);
        checkOutput({tag, ".pix_on_board"}, pix_on_board, 0);
        checkOutput({tag, ".pix_highlight"}, pix_highlight, 0);
        checkOutput({tag, ".pix_blank"}, pix_blank, 0);
    endtask

    // Runs one pixel through the pipe and checks its highlight and on-board
    // flags when it reaches the outputs.
    task automatic checkPixelFlags(input int x, input int y, input int expHl, input int expOn);
        advanceTo(x, y);
        repeat (4) stepBeam(0, 0, 0);
        checkOutput($sformatf("hl@%0d,%0d", x, y), pix_highlight, expHl);
        checkOutput($sformatf("on@%0d,%0d", x, y), pix_on_board, expOn);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) hist[i] = '{default: 0};

        //          x    y    code  rq  addr   rom   idx pc  blk drk on  hl
        vecs[0]  = '{100, 20,  1,   2,  0,     0,     2,  1,  0,  0,  1,  0};
        vecs[1]  = '{154, 20,  3,   1,  0,     6104,  1,  1,  0,  0,  1,  0};
        vecs[2]  = '{155, 21,  0,   3,  1,     0,     0,  0,  0,  1,  1,  0};
        vecs[3]  = '{539, 21,  6,   0,  7,     15234, 0,  0,  0,  1,  1,  0};
        vecs[4]  = '{99,  22,  1,   1,  -1,    0,     0,  0,  0,  0,  0,  0};
        vecs[5]  = '{103, 22,  13,  3,  0,     12213, 3,  1,  1,  0,  1,  0};
        vecs[6]  = '{540, 23,  6,   3,  -1,    0,     0,  0,  0,  0,  0,  0};
        vecs[7]  = '{100, 75,  2,   1,  8,     3025,  1,  1,  0,  1,  1,  0};
        vecs[8]  = '{160, 75,  7,   2,  9,     0,     0,  0,  0,  0,  1,  1};
        vecs[9]  = '{120, 459, 5,   2,  56,    15090, 2,  1,  0,  1,  1,  0};
        vecs[10] = '{120, 460, 9,   1,  -1,    0,     0,  0,  0,  0,  0,  0};

        reset = 1'b1;
        DrawX = 10'd0;
        DrawY = 10'd0;
        blank = 1'b0;
        sel_sq = 6'd9;
        sel_valid = 1'b1;
        board_rd_data = 4'd0;
        rom_q = 2'd0;
        #1;
        checkAllZero("reset");
        repeat (3) applyStimulus(0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            advanceTo(vecs[i].x, vecs[i].y);
            stepBeam(1, vecs[i].code, vecs[i].rq);
            if (vecs[i].addr >= 0)
                checkOutput($sformatf("v%0d.board_rd_addr", i), board_rd_addr, vecs[i].addr);
            stepBeam(0, 0, 0);
            stepBeam(0, 0, 0);
            checkOutput($sformatf("v%0d.rom_addr", i), rom_addr, vecs[i].rom);
            stepBeam(0, 0, 0);
            checkOutput($sformatf("v%0d.pix_idx", i), pix_idx, vecs[i].idx);
            checkOutput($sformatf("v%0d.pix_is_piece", i), pix_is_piece, vecs[i].piece);
            checkOutput($sformatf("v%0d.pix_black", i), pix_black, vecs[i].black);
            checkOutput($sformatf("v%0d.pix_dark", i), pix_dark, vecs[i].dark);
            checkOutput($sformatf("v%0d.pix_on_board", i), pix_on_board, vecs[i].on);
            checkOutput($sformatf("v%0d.pix_highlight", i), pix_highlight, vecs[i].hl);
        end

        // Selection changed mid-frame: old square keeps the highlight until
        // the next frame starts.
        advanceTo(0, 100);
        sel_sq = 6'd10;
        checkPixelFlags(160, 100, 1, 1);
        checkPixelFlags(215, 100, 0, 1);
        checkPixelFlags(160, 80, 0, 1);
        checkPixelFlags(215, 80, 1, 1);

        // Random frame: random selection, random board and ROM contents, a
        // random subset of lines scanned in full plus the edge rows.
        advanceTo(0, 0);
        sel_sq = 6'($urandom_range(0, 63));
        sel_valid = 1'($urandom_range(0, 1));
        for (int y = 0; y < 525; y++) begin
            if ($urandom_range(0, 23) == 0 || y == 20 || y == 459 || y == 460) begin
                repeat (800) stepBeam(0, 0, 0);
            end else begin
                applyStimulus(0, by, 0, 0, 0);
                by = (by + 1) % 525;
            end
        end

        // Mid-frame reset: outputs clear at once, and nothing is drawn again
        // until the first board row of the following frame.
        sel_valid = 1'b1;
        advanceTo(250, 200);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("midreset");
        for (int i = 0; i < 8; i++) hist[i].valid = 0;
        synced = 0;
        selLv = 0;
        repeat (3) stepBeam(0, 0, 0);
        reset = 1'b0;
        checkPixelFlags(300, 300, 0, 0);
        checkPixelFlags(300, 20, 0, 1);
        repeat (10) stepBeam(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
